// File: rtl/shift_detect_n_if.sv
// Signal bundle between the shift/detect core and its user.
// The user drives the shift and load controls; the core returns register state and match status.
interface shift_detect_n_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 4
);
   logic             a;
   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] r;
   logic             match;
   logic             zero;
   logic [CNT_W-1:0] mcount;

   modport master (output a, en, dir, load, din, input r, match, zero, mcount);
   modport slave  (input a, en, dir, load, din, output r, match, zero, mcount);
endinterface

// File: rtl/shift_detect_n.sv
// Bidirectional shift register with parallel load, pattern-match pulse and saturating match counter.
// Matching is armed only once WIDTH valid bits are present (fill counter / FILL-ARMED FSM).
module shift_detect_n #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
   parameter int unsigned      CNT_W   = 4,
   parameter bit               OVERLAP = 1'b1
) (
   input logic             clk,
   input logic             resetn,
   shift_detect_n_if.slave bus
);
   localparam int unsigned      FW      = $clog2(WIDTH + 1);
   localparam logic [FW-1:0]    FULL    = FW'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {FILL, ARMED} state_e;

   state_e           state_q,  state_d;
   logic [FW-1:0]    fill_q,   fill_d;
   logic [WIDTH-1:0] r_q,      r_d;
   logic             match_q,  match_d;
   logic [CNT_W-1:0] mcount_q, mcount_d;

   logic [WIDTH-1:0] shifted;
   logic [FW-1:0]    fill_inc;
   logic             hit;

   assign shifted  = bus.dir ? {bus.a, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], bus.a};
   assign fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
   // A shift matches only when it leaves a full window of valid bits equal to PATTERN.
   assign hit      = (fill_inc == FULL) && (shifted == PATTERN);

   // NOTE: non-blocking assignments so every register samples pre-edge values; all state is reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= FILL;
         fill_q   <= '0;
         r_q      <= '0;
         match_q  <= 1'b0;
         mcount_q <= '0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         r_q      <= r_d;
         match_q  <= match_d;
         mcount_q <= mcount_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      r_d      = r_q;
      match_d  = 1'b0;
      mcount_d = mcount_q;

      if (bus.load) begin
         r_d     = bus.din;
         fill_d  = FULL;
         state_d = ARMED;
      end else if (bus.en) begin
         r_d    = shifted;
         fill_d = fill_inc;
         unique case (state_q)
            FILL:    if (fill_inc == FULL) state_d = ARMED;
            ARMED:   state_d = ARMED;
            default: state_d = FILL;
         endcase
         if (hit) begin
            match_d = 1'b1;
            if (mcount_q != CNT_MAX) mcount_d = mcount_q + CNT_W'(1);
            if (!OVERLAP) begin
               fill_d  = '0;
               state_d = FILL;
            end
         end
      end
   end

   assign bus.r      = r_q;
   assign bus.match  = match_q;
   assign bus.mcount = mcount_q;
   assign bus.zero   = (r_q == '0);
endmodule

// File: tb/tb_shift_detect_n.sv
// Self-checking bench: three configurations (overlap, non-overlap, 2-bit counter) share one stimulus,
// checked by constant vectors, directed corner sequences and a random run against a behavioural model.
`timescale 1ns/1ps
module tb_shift_detect_n;
   localparam int W    = 4;
   localparam int PAT  = 4'b1011;
   localparam int NDUT = 3;

   typedef struct {
      logic       load, en, dir, a;
      logic [3:0] din;
      logic [3:0] exp_r;
      logic       exp_match;
      logic [3:0] exp_mcount;
      logic       exp_zero;
   } vec_t;

   logic         clk;
   logic         resetn;
   logic         a, en, dir, load;
   logic [W-1:0] din;
   int           n_checks = 0;
   int           n_pass   = 0;

   // Reference model state, one slot per DUT configuration.
   int m_r    [NDUT];
   int m_fill [NDUT];
   int m_cnt  [NDUT];
   int m_match[NDUT];
   int cfg_max[NDUT] = '{15, 15, 3};
   bit cfg_ov [NDUT] = '{1'b1, 1'b0, 1'b1};

   shift_detect_n_if #(.WIDTH(W), .CNT_W(4)) bus0 ();
   shift_detect_n_if #(.WIDTH(W), .CNT_W(4)) bus1 ();
   shift_detect_n_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

   assign bus0.a = a;  assign bus0.en = en;  assign bus0.dir = dir;  assign bus0.load = load;  assign bus0.din = din;
   assign bus1.a = a;  assign bus1.en = en;  assign bus1.dir = dir;  assign bus1.load = load;  assign bus1.din = din;
   assign bus2.a = a;  assign bus2.en = en;  assign bus2.dir = dir;  assign bus2.load = load;  assign bus2.din = din;

   shift_detect_n #(.WIDTH(W), .PATTERN(4'b1011), .CNT_W(4), .OVERLAP(1'b1)) u_ov  (.clk(clk), .resetn(resetn), .bus(bus0));
   shift_detect_n #(.WIDTH(W), .PATTERN(4'b1011), .CNT_W(4), .OVERLAP(1'b0)) u_nov (.clk(clk), .resetn(resetn), .bus(bus1));
   shift_detect_n #(.WIDTH(W), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) u_sat (.clk(clk), .resetn(resetn), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++) begin
         m_r[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_match[i] = 0;
      end
   endtask

   // One rising edge of the specified behaviour, using the inputs present before the edge.
   task automatic model_clock();
      for (int i = 0; i < NDUT; i++) begin
         m_match[i] = 0;
         if (load) begin
            m_r[i]    = int'(din);
            m_fill[i] = W;
         end else if (en) begin
            if (dir) m_r[i] = (int'(a) << (W - 1)) | (m_r[i] >> 1);
            else     m_r[i] = ((m_r[i] << 1) | int'(a)) % (1 << W);
            if (m_fill[i] < W) m_fill[i]++;
            if (m_fill[i] == W && m_r[i] == PAT) begin
               m_match[i] = 1;
               if (m_cnt[i] < cfg_max[i]) m_cnt[i]++;
               if (!cfg_ov[i]) m_fill[i] = 0;
            end
         end
      end
   endtask

   task automatic get_dut(int i, output int r, output int m, output int c, output int z);
      case (i)
         0:       begin r = int'(bus0.r); m = int'(bus0.match); c = int'(bus0.mcount); z = int'(bus0.zero); end
         1:       begin r = int'(bus1.r); m = int'(bus1.match); c = int'(bus1.mcount); z = int'(bus1.zero); end
         default: begin r = int'(bus2.r); m = int'(bus2.match); c = int'(bus2.mcount); z = int'(bus2.zero); end
      endcase
   endtask

   task automatic compare_all(string tag);
      int r, m, c, z;
      for (int i = 0; i < NDUT; i++) begin
         get_dut(i, r, m, c, z);
         check($sformatf("%s.dut%0d.r", tag, i), r, m_r[i]);
         check($sformatf("%s.dut%0d.match", tag, i), m, m_match[i]);
         check($sformatf("%s.dut%0d.mcount", tag, i), c, m_cnt[i]);
         check($sformatf("%s.dut%0d.zero", tag, i), z, int'(m_r[i] == 0));
      end
   endtask

   task automatic set_in(logic l, logic e, logic d, logic b, logic [W-1:0] p);
      load = l; en = e; dir = d; a = b; din = p;
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      #1;
      if (resetn) model_clock();
      compare_all(tag);
   endtask

   task automatic shift_left(logic b, string tag);
      set_in(1'b0, 1'b1, 1'b0, b, '0);
      tick(tag);
   endtask

   // Asserts reset mid-cycle and checks its asynchronous effect before any clock edge.
   task automatic assert_reset();
      #3;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
      resetn = 1'b0;
      model_reset();
      #1;
      compare_all("rst_async");
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b1;
   endtask

   function automatic vec_t mk(logic l, logic e, logic d, logic b, logic [3:0] p,
                               logic [3:0] er, logic em, logic [3:0] ec, logic ez);
      vec_t v;
      v.load = l; v.en = e; v.dir = d; v.a = b; v.din = p;
      v.exp_r = er; v.exp_match = em; v.exp_mcount = ec; v.exp_zero = ez;
      return v;
   endfunction

   initial begin
      vec_t tbl[13];
      logic nov_bits[11] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
      int   sat_exp[5]   = '{1, 2, 3, 3, 3};

      resetn = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
      model_reset();

      // Expected values for the overlapping default configuration.
      tbl[0]  = mk(0, 1, 0, 1, 4'h0, 4'b0001, 0, 4'd0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 4'h0, 4'b0010, 0, 4'd0, 0);
      tbl[2]  = mk(0, 1, 0, 1, 4'h0, 4'b0101, 0, 4'd0, 0);
      tbl[3]  = mk(0, 1, 0, 1, 4'h0, 4'b1011, 1, 4'd1, 0);
      tbl[4]  = mk(0, 1, 0, 0, 4'h0, 4'b0110, 0, 4'd1, 0);
      tbl[5]  = mk(0, 1, 0, 1, 4'h0, 4'b1101, 0, 4'd1, 0);
      tbl[6]  = mk(0, 1, 0, 1, 4'h0, 4'b1011, 1, 4'd2, 0);
      tbl[7]  = mk(0, 0, 0, 1, 4'h0, 4'b1011, 0, 4'd2, 0);
      tbl[8]  = mk(1, 1, 1, 0, 4'hB, 4'b1011, 0, 4'd2, 0);
      tbl[9]  = mk(0, 1, 1, 0, 4'h0, 4'b0101, 0, 4'd2, 0);
      tbl[10] = mk(0, 1, 1, 1, 4'h0, 4'b1010, 0, 4'd2, 0);
      tbl[11] = mk(0, 1, 0, 1, 4'h0, 4'b0101, 0, 4'd2, 0);
      tbl[12] = mk(0, 1, 0, 1, 4'h0, 4'b1011, 1, 4'd3, 0);

      assert_reset();
      check("reset.r", int'(bus0.r), 0);
      check("reset.match", int'(bus0.match), 0);
      check("reset.mcount", int'(bus0.mcount), 0);
      check("reset.zero", int'(bus0.zero), 1);
      release_reset();

      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].load, tbl[i].en, tbl[i].dir, tbl[i].a, tbl[i].din);
         tick($sformatf("vec%0d", i));
         check($sformatf("vec%0d.r", i), int'(bus0.r), int'(tbl[i].exp_r));
         check($sformatf("vec%0d.match", i), int'(bus0.match), int'(tbl[i].exp_match));
         check($sformatf("vec%0d.mcount", i), int'(bus0.mcount), int'(tbl[i].exp_mcount));
         check($sformatf("vec%0d.zero", i), int'(bus0.zero), int'(tbl[i].exp_zero));
      end

      // Non-overlapping: the tail of one match cannot start the next.
      assert_reset();
      release_reset();
      for (int i = 0; i < 11; i++) begin
         shift_left(nov_bits[i], $sformatf("nov%0d", i));
         if (i == 6) begin
            check("nov.r7", int'(bus1.r), PAT);
            check("nov.match7", int'(bus1.match), 0);
            check("nov.mcount7", int'(bus1.mcount), 1);
            check("ov.mcount7", int'(bus0.mcount), 2);
         end
         if (i == 10) begin
            check("nov.match11", int'(bus1.match), 1);
            check("nov.mcount11", int'(bus1.mcount), 2);
         end
      end

      // Two-bit counter saturates at 3 without wrapping.
      assert_reset();
      release_reset();
      shift_left(1'b1, "sat"); shift_left(1'b0, "sat"); shift_left(1'b1, "sat"); shift_left(1'b1, "sat");
      check("sat.match0", int'(bus2.match), 1);
      check("sat.mcount0", int'(bus2.mcount), sat_exp[0]);
      for (int k = 1; k < 5; k++) begin
         shift_left(1'b0, "sat");
         check($sformatf("sat.nomatch%0d", k), int'(bus2.match), 0);
         shift_left(1'b1, "sat");
         shift_left(1'b1, "sat");
         check($sformatf("sat.match%0d", k), int'(bus2.match), 1);
         check($sformatf("sat.mcount%0d", k), int'(bus2.mcount), sat_exp[k]);
      end

      // Loading the pattern never matches; a subsequent right shift does not match either.
      assert_reset();
      release_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
      tick("load");
      check("load.r", int'(bus0.r), 4'b1011);
      check("load.match", int'(bus0.match), 0);
      check("load.mcount", int'(bus0.mcount), 0);
      set_in(1'b0, 1'b1, 1'b1, 1'b1, '0);
      tick("load_shr");
      check("load_shr.r", int'(bus0.r), 4'b1101);
      check("load_shr.match", int'(bus0.match), 0);

      // Zero flag tracks r; holding keeps r and suppresses match.
      assert_reset();
      release_reset();
      shift_left(1'b1, "zero");
      check("zero.r", int'(bus0.r), 1);
      check("zero.flag", int'(bus0.zero), 0);
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, 1'b0, 1'b0, 1'b1, '0);
         tick("hold");
         check($sformatf("hold%0d.r", k), int'(bus0.r), 1);
         check($sformatf("hold%0d.match", k), int'(bus0.match), 0);
      end

      // Reset mid-pattern discards progress; a match needs four fresh shifts after release.
      shift_left(1'b0, "mid"); shift_left(1'b1, "mid"); shift_left(1'b1, "mid");
      shift_left(1'b1, "mid"); shift_left(1'b0, "mid"); shift_left(1'b1, "mid");
      assert_reset();
      check("midrst.r", int'(bus0.r), 0);
      check("midrst.mcount", int'(bus0.mcount), 0);
      check("midrst.zero", int'(bus0.zero), 1);
      release_reset();
      shift_left(1'b1, "post");
      check("post.match1", int'(bus0.match), 0);
      check("post.r1", int'(bus0.r), 1);
      shift_left(1'b0, "post"); shift_left(1'b1, "post"); shift_left(1'b1, "post");
      check("post.match4", int'(bus0.match), 1);
      check("post.mcount4", int'(bus0.mcount), 1);

      // Random traffic against the model, with occasional asynchronous resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            assert_reset();
            release_reset();
         end
         set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, 1'($urandom), W'($urandom));
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/shift_detect_n.md
SHIFT_DETECT_N -- requirements
Module: shift_detect_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, shift-register width (legal 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b1011, WIDTH-bit match pattern.
REQ-003 SHALL provide parameter CNT_W, default 4, match-counter width (legal 1..16).
REQ-004 SHALL provide parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port a  input  1  serial data in.
REQ-008 SHALL have port en  input  1  shift enable.
REQ-009 SHALL have port dir  input  1  0 = shift left (a into bit 0), 1 = shift right (a into bit WIDTH-1).
REQ-010 SHALL have port load  input  1  parallel load strobe.
REQ-011 SHALL have port din  input  WIDTH  parallel load data.
REQ-012 SHALL have port r  output  WIDTH  shift-register contents, registered.
REQ-013 SHALL have port match  output  1  one-cycle pattern-match pulse, registered.
REQ-014 SHALL have port zero  output  1  high whenever r == 0, combinational from r.
REQ-015 SHALL have port mcount  output  CNT_W  saturating count of match pulses, registered.

Function
REQ-016 Priority per edge SHALL be: load > en > hold.
REQ-017 load=1: r <= din; fill <= WIDTH (state ARMED); match <= 0; mcount unchanged.
REQ-018 en=1, load=0, dir=0: r <= {r[WIDTH-2:0], a}; dir=1: r <= {a, r[WIDTH-1:1]}.
REQ-019 en=0, load=0: r, fill, state, mcount SHALL hold; match <= 0.
REQ-020 Internal fill counter (0..WIDTH) SHALL count valid shifted bits; increments per shift, saturates at WIDTH.
REQ-021 FSM SHALL have states FILL (fill < WIDTH) and ARMED (fill == WIDTH); FILL -> ARMED on the shift bringing fill to WIDTH; ARMED -> FILL only on match with OVERLAP=0 or on reset.
REQ-022 match SHALL be 1 in exactly the cycle where r first shows PATTERN as the result of a shift, provided that shift leaves fill == WIDTH; otherwise 0.
REQ-023 Load SHALL never produce a match, even if din == PATTERN.
REQ-024 OVERLAP=0: on a match, fill SHALL be cleared to 0 (state FILL), so the next match needs WIDTH fresh shifts.
REQ-025 OVERLAP=1: fill SHALL stay WIDTH after match; consecutive shifts may each match.
REQ-026 mcount SHALL increment by 1 in the same edge match is set, saturating at 2^CNT_W-1 (no wrap).
REQ-027 Latency: r, match, mcount SHALL all update on the same edge; zero follows r with no added cycle.

Reset
REQ-028 resetn=0 SHALL asynchronously force r=0, match=0, mcount=0, fill=0, state FILL; thus zero=1.
REQ-029 Reset mid-shift or mid-match SHALL discard all progress; first match after release needs WIDTH shifts.
REQ-030 Release of resetn SHALL take effect on the first rising clk edge after deassertion; no other input SHALL be sampled while resetn=0.

Verification
REQ-031 Defaults, dir=0, en=1, a=1,0,1,1 on 4 edges -> r=1011 after 4th edge, match=1 that cycle only, mcount=1, zero=0.
REQ-032 Continue a=0,1,1: OVERLAP=1 -> r=1011 after 3rd edge, match pulse, mcount=2; OVERLAP=0 -> no match (fill=3), a further 4 shifts 1,0,1,1 -> match, mcount=2.
REQ-033 load=1, din=1011 -> r=1011, match=0, mcount=0; then en=1, dir=1, a=1 -> r=1101, no match.
REQ-034 CNT_W=2, OVERLAP=1, produce 5 matches -> mcount=1,2,3,3,3.
REQ-035 After reset zero=1; shift a=1 -> r=0001, zero=0; en=0 for 5 cycles -> r stays 0001, match=0.
REQ-036 Assert resetn=0 between clk edges after 3 of 4 pattern bits -> r=0, mcount=0 immediately; after release, bit 4 alone -> no match.
